// File: rtl/multicycle_core.sv
// Multi-cycle datapath: loadable imem, 32-entry register file, dmem,
// and a FETCH/DECODE/EXEC/MEM/WB sequencer that runs until HALT_WORD.
module multicycle_core #(
  parameter int          DATA_W     = 32,
  parameter int          IMEM_DEPTH = 16,
  parameter int          DMEM_DEPTH = 16,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int         IA_W       = $clog2(IMEM_DEPTH),
  localparam int         DA_W       = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              prog_we,
  input  logic [IA_W-1:0]   prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [4:0]        probe_addr,
  output logic [DATA_W-1:0] probe_data,
  output logic [IA_W-1:0]   pc,
  output logic [DATA_W-1:0] alu_result,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  state_t state;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] rf   [32];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [31:0]       ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mdr;

  logic              reg_dst;
  logic              alu_src;
  logic [2:0]        alu_ctl;
  logic              mem_to_reg;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic signed [15:0] imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_y;
  logic              is_store;
  logic              is_load;
  logic [4:0]        dest;
  logic [DATA_W-1:0] wb_data;
  logic [DA_W-1:0]   daddr;

  assign reg_dst    = ir[31];
  assign alu_src    = ir[30];
  assign alu_ctl    = ir[29:27];
  assign mem_to_reg = ir[26];
  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign rd         = ir[15:11];
  assign imm16      = ir[15:0];
  assign imm_ext    = DATA_W'(imm16);

  assign is_store = reg_dst & alu_src;
  assign is_load  = ~reg_dst & alu_src & mem_to_reg;
  assign opb      = alu_src ? imm_ext : b;
  assign dest     = reg_dst ? rd : rt;
  assign wb_data  = is_load ? mdr : alu_out;
  assign daddr    = alu_out[DA_W-1:0];

  assign probe_data = rf[probe_addr];
  assign alu_result = alu_out;

  always_comb begin
    alu_y = '0;
    unique case (alu_ctl)
      3'b000: alu_y = a & opb;
      3'b001: alu_y = a | opb;
      3'b010: alu_y = a + opb;
      3'b011: alu_y = a ^ opb;
      3'b100: alu_y = a << opb[4:0];
      3'b101: alu_y = a >> opb[4:0];
      3'b110: alu_y = a - opb;
      3'b111: alu_y = ($signed(a) < $signed(opb))
                      ? DATA_W'(1) : '0;
    endcase
  end

  // Program memory survives reset; busy fences off writes while running.
  always_ff @(posedge clk) begin
    if (prog_we && !busy)
      imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      a           <= '0;
      b           <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      instr_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++)
        dmem[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            instr_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          if (ir == HALT_WORD) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out <= alu_y;
          state   <= (is_load || is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (is_store) begin
            dmem[daddr] <= b;
            if (instr_count != 16'hFFFF)
              instr_count <= instr_count + 16'd1;
            state <= S_FETCH;
          end else begin
            mdr   <= dmem[daddr];
            state <= S_WB;
          end
        end
        S_WB: begin
          if (dest != 5'd0)
            rf[dest] <= wb_data;
          if (instr_count != 16'hFFFF)
            instr_count <= instr_count + 16'd1;
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: ISA-level model with per-cycle timeline
// compare plus hand-computed expectations.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [4:0]  probe_addr = '0;
  logic [31:0] probe_data;
  logic [3:0]  pc;
  logic [31:0] alu_result;
  logic [15:0] instr_count;

  multicycle_core dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .probe_addr(probe_addr), .probe_data(probe_data), .pc(pc),
    .alu_result(alu_result), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] m_imem [16];
  logic [31:0] m_rf   [32];
  logic [31:0] m_dmem [16];
  logic [31:0] m_alu;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] mk(input bit rdst, input bit asrc,
      input logic [2:0] op, input bit m2r, input logic [4:0] rs_,
      input logic [4:0] rt_, input logic [15:0] imm);
    return {rdst, asrc, op, m2r, rs_, rt_, imm};
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op,
      input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd3: return x ^ y;
      3'd4: return x << y[4:0];
      3'd5: return x >> y[4:0];
      3'd6: return x - y;
      default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic void push(bit b, bit d, int p, int c);
    exp_t e;
    e.busy = b; e.done = d; e.pc = 4'(p); e.cnt = 16'(c);
    q.push_back(e);
  endfunction

  // Executes up to max_instr instructions from address 0, recording
  // what busy/done/pc/instr_count must read on each following cycle.
  function automatic void model_run(input int max_instr);
    int p = 0;
    int cnt = 0;
    int cpi;
    logic [31:0] w, av, bv, imm, y;
    logic [4:0] d;
    while (cnt < max_instr) begin
      w = m_imem[p];
      if (w == HALT) begin
        push(1, 0, p, cnt);
        push(1, 0, (p + 1) % 16, cnt);
        push(0, 1, (p + 1) % 16, cnt);
        return;
      end
      imm = {{16{w[15]}}, w[15:0]};
      av  = m_rf[w[25:21]];
      bv  = m_rf[w[20:16]];
      y   = alu(w[29:27], av, w[30] ? imm : bv);
      m_alu = y;
      cpi = 4;
      if (w[31] && w[30]) begin
        m_dmem[y[3:0]] = bv;
      end else if (!w[31] && w[30] && w[26]) begin
        cpi = 5;
        if (w[20:16] != 0) m_rf[w[20:16]] = m_dmem[y[3:0]];
      end else begin
        d = w[31] ? w[15:11] : w[20:16];
        if (d != 0) m_rf[d] = y;
      end
      push(1, 0, p, cnt);
      for (int k = 1; k < cpi; k++) push(1, 0, (p + 1) % 16, cnt);
      cnt++;
      p = (p + 1) % 16;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < 16; i++) m_dmem[i] = '0;
    m_alu = '0;
    q.delete();
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("busy", 64'(busy), 64'(e.busy));
      chk("done", 64'(done), 64'(e.done));
      chk("pc", 64'(pc), 64'(e.pc));
      chk("instr_count", 64'(instr_count), 64'(e.cnt));
    end
  end

  task automatic prog_write(input logic [3:0] a_, input logic [31:0] d_);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a_; prog_data = d_;
    m_imem[a_] = d_;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 32; i++) begin
      probe_addr = 5'(i);
      #1 chk($sformatf("rf[%0d]", i), 64'(probe_data), 64'(m_rf[i]));
    end
  endtask

  task automatic probe(input int r, input logic [31:0] exp);
    probe_addr = 5'(r);
    #1 chk($sformatf("lit rf[%0d]", r), 64'(probe_data), 64'(exp));
  endtask

  task automatic run(input int max_instr, input bit wr,
      input logic [3:0] wa, input logic [31:0] wd, input bit poke,
      output int nbusy);
    int len;
    @(negedge clk);
    start = 1'b1;
    if (wr) begin
      prog_we = 1'b1; prog_addr = wa; prog_data = wd;
      m_imem[wa] = wd;
    end
    @(posedge clk);
    model_run(max_instr);
    #1 start = 1'b0; prog_we = 1'b0;
    len = q.size();
    nbusy = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (poke && i == 5) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd10;
        prog_data = mk(0, 1, 3'd2, 0, 5'd0, 5'd13, 16'd1);
      end
      if (poke && i == 6) begin
        start = 1'b0; prog_we = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst pc", 64'(pc), 0);
    chk("rst alu", 64'(alu_result), 0);
    chk("rst cnt", 64'(instr_count), 0);
    check_rf();
    @(negedge clk) rst = 1'b1;

    // Program 1; HALT lands in the same cycle as start.
    prog_write(4'd0, mk(0, 1, 3'd2, 0, 5'd0, 5'd1, 16'd5));
    prog_write(4'd1, mk(0, 1, 3'd2, 0, 5'd0, 5'd2, 16'hFFFE));
    run(100, 1, 4'd2, HALT, 0, nb);
    chk("p1 busy cycles", 64'(nb), 10);
    chk("p1 done", 64'(done), 1);
    chk("p1 count", 64'(instr_count), 2);
    chk("p1 alu", 64'(alu_result), 64'(m_alu));
    chk("p1 alu lit", 64'(alu_result), 64'h0000_0000_FFFF_FFFE);
    probe(1, 32'd5);
    probe(2, 32'hFFFF_FFFE);
    check_rf();

    // Program 2: R-type, shifts, store/load, rt=0 write, busy pokes.
    prog_write(4'd0, mk(1, 0, 3'd6, 0, 5'd1, 5'd2, {5'd3, 11'd0}));
    prog_write(4'd1, mk(1, 0, 3'd7, 0, 5'd2, 5'd1, {5'd4, 11'd0}));
    prog_write(4'd2, mk(0, 1, 3'd2, 0, 5'd0, 5'd5, 16'd33));
    prog_write(4'd3, mk(1, 0, 3'd4, 0, 5'd1, 5'd5, {5'd7, 11'd0}));
    prog_write(4'd4, mk(1, 1, 3'd2, 0, 5'd0, 5'd1, 16'd17));
    prog_write(4'd5, mk(0, 1, 3'd2, 1, 5'd0, 5'd6, 16'd1));
    prog_write(4'd6, mk(0, 1, 3'd2, 0, 5'd1, 5'd0, 16'd9));
    prog_write(4'd7, mk(0, 0, 3'd1, 0, 5'd1, 5'd11, 16'd0));
    prog_write(4'd8, mk(1, 0, 3'd5, 0, 5'd2, 5'd5, {5'd9, 11'd0}));
    prog_write(4'd9, mk(0, 1, 3'd0, 0, 5'd2, 5'd10, 16'h00F0));
    prog_write(4'd10, HALT);
    run(100, 0, 4'd0, 32'd0, 1, nb);
    chk("p2 busy cycles", 64'(nb), 43);
    chk("p2 done", 64'(done), 1);
    chk("p2 count", 64'(instr_count), 10);
    chk("p2 alu", 64'(alu_result), 64'(m_alu));
    probe(3, 32'd7);
    probe(4, 32'd1);
    probe(7, 32'd10);
    probe(6, 32'd5);
    probe(0, 32'd0);
    probe(9, 32'h7FFF_FFFF);
    probe(10, 32'h0000_00F0);
    check_rf();

    // Program 3: no HALT, pc wraps 15 -> 0.
    for (int i = 0; i < 16; i++)
      prog_write(4'(i), mk(0, 1, 3'd2, 0, 5'd12, 5'd12, 16'd1));
    run(18, 0, 4'd0, 32'd0, 0, nb);
    @(posedge clk);
    #1;
    chk("wrap pc", 64'(pc), 2);
    chk("wrap count", 64'(instr_count), 18);
    chk("wrap busy", 64'(busy), 1);
    probe(12, 32'd18);

    // Reset while in EXEC.
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("mid rst busy", 64'(busy), 0);
    chk("mid rst done", 64'(done), 0);
    chk("mid rst pc", 64'(pc), 0);
    chk("mid rst alu", 64'(alu_result), 0);
    chk("mid rst cnt", 64'(instr_count), 0);
    probe(12, 32'd0);
    check_rf();
    @(negedge clk) rst = 1'b1;

    run(18, 0, 4'd0, 32'd0, 0, nb);
    @(posedge clk);
    #1;
    chk("rerun pc", 64'(pc), 2);
    chk("rerun count", 64'(instr_count), 18);
    probe(12, 32'd18);
    @(negedge clk) rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle switch-driven datapath. It uses the same 32-bit instruction field layout.
- Holds a loadable instruction memory, a register file, a data memory and a 5-state execution FSM with a program counter.
- Runs a loaded program from address 0 on start, until a HALT word.
- Exposes a probe port and status outputs for the board display and for simulation.

Parameters:
DATA_W, 32, datapath/register/memory word width; legal range 16..64.
IMEM_DEPTH, 16, instruction words; power of 2, minimum 4.
DMEM_DEPTH, 16, data words; power of 2, minimum 4.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends execution.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to run the program from PC=0.
busy  out  1  high from the cycle after accepted start until DONE is entered.
done  out  1  high while in DONE; cleared by the next accepted start or by reset.
prog_we  in  1  instruction memory write enable.
prog_addr  in  clog2(IMEM_DEPTH)  instruction write address.
prog_data  in  32  instruction write data.
probe_addr  in  5  register index for probe_data.
probe_data  out  DATA_W  combinational read of rf[probe_addr].
pc  out  clog2(IMEM_DEPTH)  current program counter.
alu_result  out  DATA_W  ALUOut register.
instr_count  out  16  instructions retired since the last start; saturates at 16'hFFFF.

Behaviour:
- Instruction fields:
  - [31] RegDst, [30] ALUSrc, [29:27] ALUControl, [26] MemtoReg.
  - [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
- Imm is sign-extended to DATA_W.
- Classes:
  - RegDst=1, ALUSrc=0: R-type; rd <= rs op rt.
  - RegDst=0, ALUSrc=1: I-type; rt <= rs op imm, or a load when MemtoReg=1.
  - RegDst=1, ALUSrc=1: store; dmem[rs+imm] <= rt, no register write.
  - RegDst=0, ALUSrc=0: rt <= rs op rt.
- ALUControl encodings:
  - 000 AND, 001 OR, 010 ADD, 011 XOR.
  - 100 SLL (by B[4:0]), 101 SRL (by B[4:0]), 110 SUB, 111 SLT (signed, result 0/1).
- Arithmetic is modulo 2^DATA_W; no overflow flag.
- rf[0] always reads 0; writes to it are discarded.
- Data address is the low clog2(DMEM_DEPTH) bits of ALUOut (wrap-around).
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
  - IDLE/DONE + start -> FETCH, with pc <= 0 and instr_count <= 0.
  - FETCH: IR <= imem[pc]; pc <= pc+1. Wraps IMEM_DEPTH-1 -> 0.
  - DECODE: A <= rf[rs], B <= rf[rt]. If IR==HALT_WORD -> DONE; otherwise -> EXEC.
  - EXEC: ALUOut <= A op (ALUSrc ? imm : B). Load/store -> MEM; otherwise -> WB.
  - MEM: store writes and retires -> FETCH; load latches MDR -> WB.
  - WB: writes ALUOut, or MDR when MemtoReg=1, to rd/rt; retires -> FETCH.
- Cycles per instruction: ALU 4, store 4, load 5. HALT takes 2 cycles and is not counted in instr_count.
- start is ignored while busy.
- prog_we is ignored while busy; it is accepted in IDLE/DONE. A write and a start in the same cycle: the write lands first, and the program sees it.
- Reset (any time, including mid-instruction):
  - State -> IDLE; pc, IR, A, B, ALUOut, MDR, instr_count, all rf entries and all dmem words -> 0.
  - busy=0, done=0, alu_result=0.
  - imem is not reset; the program survives reset.

Test Plan:
- Load imem[0]=I-type ADD rt=1 rs=0 imm=5, imem[1]=I-type ADD rt=2 imm=-2, imem[2]=HALT; pulse start -> done after 4+4+2 cycles, rf[1]=5, rf[2]=DATA_W'(-2), instr_count=2, busy high throughout.
- R-type SUB rd=3 = rf[1]-rf[2] after the above; SLT rd=4 = rf[2]<rf[1] -> probe rf[3]=7, rf[4]=1; SLL with B=33 shifts by 1.
- Store rf[1]=5 to rs=0+imm=17 with DMEM_DEPTH=16 -> dmem[1]=5; load back to rt=6 -> rf[6]=5, 5-cycle load verified.
- Write to rt=0 -> probe rf[0] stays 0; program with no HALT in 16 words wraps pc 15->0 and continues running.
- Assert rst low in EXEC -> immediately IDLE, all outputs 0, rf cleared; next start reruns the retained program with identical results.
- start and prog_we pulsed while busy -> no effect on pc, instr_count or imem contents.
